// File: rtl/controller_sequencer_if.sv
// Control-unit bus: run/program select and opcode in, 12-bit control word, halt flag and ring state out.
// Latency: wires only.
// Backpressure: none; the sequencer is the only driver of the control word.
interface controller_sequencer_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic                    run_not_prog;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    Cp;
    logic                    Ep;
    logic                    Lm_bar;
    logic                    CE_bar;
    logic                    Li_bar;
    logic                    Ei_bar;
    logic                    La_bar;
    logic                    Ea;
    logic                    Su;
    logic                    Eu;
    logic                    Lb_bar;
    logic                    Lo_bar;
    logic                    hlt;
    logic [5:0]              t_state;

    // The sequencer drives the control word and observes mode and opcode.
    modport master (
        input  run_not_prog, opcode,
        output Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar,
               Ea, Su, Eu, Lb_bar, Lo_bar, hlt, t_state
    );

    // Datapath / front-panel side.
    modport slave (
        output run_not_prog, opcode,
        input  Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar,
               Ea, Su, Eu, Lb_bar, Lo_bar, hlt, t_state
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: one-hot T1..T6 ring counter plus combinational microinstruction decode.
// Latency: control word is combinational from the held T-state and opcode; state advances one step per clock.
// Backpressure: ring counter holds on hlt or program mode; both force an idle control word.
module controller_sequencer #(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    controller_sequencer_if.master bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Control word in natural (active-high) polarity; bar outputs are inverted at the edge.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

    t_state_e state_q;
    t_state_e state_d;
    logic     hlt_q;
    logic     hlt_d;
    ctrl_t    cw;
    logic     active;

    // State and halt flag register; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt_q   <= hlt_d;
        end
    end

    // Next state: halt freezes, program mode parks at T1, otherwise step the ring.
    always_comb begin
        state_d = state_q;
        hlt_d   = hlt_q;
        if (hlt_q) begin
            state_d = state_q;
        end else if (!bus.run_not_prog) begin
            state_d = T1;
        end else begin
            unique case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    state_d = T5;
                    // HLT is decoded in T4; the ring then freezes in T5.
                    if (bus.opcode == OP_HLT) begin
                        hlt_d = 1'b1;
                    end
                end
                T5: state_d = T6;
                T6: state_d = T1;
                default: state_d = T1;
            endcase
        end
    end

    // Only decode when running; reset, halt and program mode all force the idle word.
    assign active = !clr && bus.run_not_prog && !hlt_q;

    // Microinstruction decode: one signal group per T-state.
    always_comb begin
        cw = '0;
        if (active) begin
            unique case (state_q)
                T1: begin
                    cw.ep = 1'b1;
                    cw.lm = 1'b1;
                end
                T2: cw.cp = 1'b1;
                T3: begin
                    cw.ce = 1'b1;
                    cw.li = 1'b1;
                end
                T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        cw.ei = 1'b1;
                        cw.lm = 1'b1;
                    end else if (bus.opcode == OP_OUT) begin
                        cw.ea = 1'b1;
                        cw.lo = 1'b1;
                    end
                end
                T5: begin
                    if (bus.opcode == OP_LDA) begin
                        cw.ce = 1'b1;
                        cw.la = 1'b1;
                    end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        cw.ce = 1'b1;
                        cw.lb = 1'b1;
                    end
                end
                T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        cw.eu = 1'b1;
                        cw.la = 1'b1;
                        cw.su = (bus.opcode == OP_SUB);
                    end
                end
                default: cw = '0;
            endcase
        end
    end

    assign bus.Cp      = cw.cp;
    assign bus.Ep      = cw.ep;
    assign bus.Lm_bar  = ~cw.lm;
    assign bus.CE_bar  = ~cw.ce;
    assign bus.Li_bar  = ~cw.li;
    assign bus.Ei_bar  = ~cw.ei;
    assign bus.La_bar  = ~cw.la;
    assign bus.Ea      = cw.ea;
    assign bus.Su      = cw.su;
    assign bus.Eu      = cw.eu;
    assign bus.Lb_bar  = ~cw.lb;
    assign bus.Lo_bar  = ~cw.lo;
    assign bus.hlt     = hlt_q;
    assign bus.t_state = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for the SAP-1 control unit: per-cycle vector table checked through an expectation queue.
// Latency: expectations are compared at the negedge of the cycle they were driven in.
// Backpressure: n/a; every cycle drives one vector and consumes one expectation.
module tb_controller_sequencer;

    // Control word packing: {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
    localparam logic [11:0] IDLE = 12'h3E3;
    localparam logic [11:0] M_CP = 12'h800;
    localparam logic [11:0] M_EP = 12'h400;
    localparam logic [11:0] M_LM = 12'h200;
    localparam logic [11:0] M_CE = 12'h100;
    localparam logic [11:0] M_LI = 12'h080;
    localparam logic [11:0] M_EI = 12'h040;
    localparam logic [11:0] M_LA = 12'h020;
    localparam logic [11:0] M_EA = 12'h010;
    localparam logic [11:0] M_SU = 12'h008;
    localparam logic [11:0] M_EU = 12'h004;
    localparam logic [11:0] M_LB = 12'h002;
    localparam logic [11:0] M_LO = 12'h001;

    // Asserting a signal flips its idle bit, whatever its polarity.
    localparam logic [11:0] F1   = IDLE ^ (M_EP | M_LM);
    localparam logic [11:0] F2   = IDLE ^ M_CP;
    localparam logic [11:0] F3   = IDLE ^ (M_CE | M_LI);
    localparam logic [11:0] E4M  = IDLE ^ (M_EI | M_LM);
    localparam logic [11:0] LDA5 = IDLE ^ (M_CE | M_LA);
    localparam logic [11:0] ADD5 = IDLE ^ (M_CE | M_LB);
    localparam logic [11:0] ADD6 = IDLE ^ (M_EU | M_LA);
    localparam logic [11:0] SUB6 = IDLE ^ (M_EU | M_LA | M_SU);
    localparam logic [11:0] OUT4 = IDLE ^ (M_EA | M_LO);

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    typedef struct {
        logic       clr;
        logic       run;
        logic [3:0] op;
        logic       chk;   // 0: state/hlt unknown this cycle, check control word only
        logic [5:0] t;
        logic [11:0] cw;
        logic       h;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    controller_sequencer_if #(.OPCODE_WIDTH(4)) bus ();

    controller_sequencer #(.OPCODE_WIDTH(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] cur_cw();
        return {bus.Cp, bus.Ep, bus.Lm_bar, bus.CE_bar, bus.Li_bar, bus.Ei_bar,
                bus.La_bar, bus.Ea, bus.Su, bus.Eu, bus.Lb_bar, bus.Lo_bar};
    endfunction

    task automatic add(input logic c, input logic r, input logic [3:0] o, input logic k,
                       input logic [5:0] t, input logic [11:0] w, input logic h);
        vec_t v;
        v.clr = c; v.run = r; v.op = o; v.chk = k; v.t = t; v.cw = w; v.h = h;
        vecs.push_back(v);
    endtask

    // W-bus contention and one-hot ring checks, applied every sampled cycle.
    task automatic check_invariants(input int idx);
        int drv;
        drv = int'(bus.Ep) + int'(!bus.CE_bar) + int'(!bus.Ei_bar) + int'(bus.Ea) + int'(bus.Eu);
        checks++;
        if (drv > 1) begin
            failures++;
            $display("FAIL bus_contention vec=%0d drivers=%0d required<=1", idx, drv);
        end
        checks++;
        if (!$onehot(bus.t_state)) begin
            failures++;
            $display("FAIL t_state_onehot vec=%0d got=%b", idx, bus.t_state);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t e);
        logic [11:0] w;
        w = cur_cw();
        checks++;
        if (w !== e.cw) begin
            failures++;
            $display("FAIL ctrl_word vec=%0d got=%h required=%h", idx, w, e.cw);
        end
        if (e.chk) begin
            checks++;
            if (bus.t_state !== e.t) begin
                failures++;
                $display("FAIL t_state vec=%0d got=%b required=%b", idx, bus.t_state, e.t);
            end
            checks++;
            if (bus.hlt !== e.h) begin
                failures++;
                $display("FAIL hlt vec=%0d got=%b required=%b", idx, bus.hlt, e.h);
            end
        end
        check_invariants(idx);
    endtask

    initial begin
        vec_t e;
        clr = 1'b1;
        bus.run_not_prog = 1'b1;
        bus.opcode = 4'h0;

        // Reset from an arbitrary state: wander randomly first.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            clr = 1'b0;
            bus.run_not_prog = ($urandom_range(0, 3) != 0);
            bus.opcode = 4'($urandom_range(0, 15));
            @(negedge clk);
            check_invariants(-1 - i);
        end

        // Reset for two clocks, then LDA.
        add(1, 1, 4'h0, 0, S1, IDLE, 0);
        add(1, 1, 4'h0, 1, S1, IDLE, 0);
        add(0, 1, 4'h0, 1, S1, F1,   0);
        add(0, 1, 4'h0, 1, S2, F2,   0);
        add(0, 1, 4'h0, 1, S3, F3,   0);
        add(0, 1, 4'h0, 1, S4, E4M,  0);
        add(0, 1, 4'h0, 1, S5, LDA5, 0);
        add(0, 1, 4'h0, 1, S6, IDLE, 0);
        // ADD
        add(0, 1, 4'h1, 1, S1, F1,   0);
        add(0, 1, 4'h1, 1, S2, F2,   0);
        add(0, 1, 4'h1, 1, S3, F3,   0);
        add(0, 1, 4'h1, 1, S4, E4M,  0);
        add(0, 1, 4'h1, 1, S5, ADD5, 0);
        add(0, 1, 4'h1, 1, S6, ADD6, 0);
        // SUB
        add(0, 1, 4'h2, 1, S1, F1,   0);
        add(0, 1, 4'h2, 1, S2, F2,   0);
        add(0, 1, 4'h2, 1, S3, F3,   0);
        add(0, 1, 4'h2, 1, S4, E4M,  0);
        add(0, 1, 4'h2, 1, S5, ADD5, 0);
        add(0, 1, 4'h2, 1, S6, SUB6, 0);
        // OUT
        add(0, 1, 4'hE, 1, S1, F1,   0);
        add(0, 1, 4'hE, 1, S2, F2,   0);
        add(0, 1, 4'hE, 1, S3, F3,   0);
        add(0, 1, 4'hE, 1, S4, OUT4, 0);
        add(0, 1, 4'hE, 1, S5, IDLE, 0);
        add(0, 1, 4'hE, 1, S6, IDLE, 0);
        // HLT: frozen at T5 for 20 clocks, run toggled and opcode changed meanwhile.
        add(0, 1, 4'hF, 1, S1, F1,   0);
        add(0, 1, 4'hF, 1, S2, F2,   0);
        add(0, 1, 4'hF, 1, S3, F3,   0);
        add(0, 1, 4'hF, 1, S4, IDLE, 0);
        for (int i = 0; i < 20; i++) begin
            add(0, !(i >= 8 && i < 12), (i >= 14) ? 4'h1 : 4'hF, 1, S5, IDLE, 1);
        end
        add(1, 1, 4'h1, 1, S5, IDLE, 1);
        // ADD interrupted by program mode in T5.
        add(0, 1, 4'h1, 1, S1, F1,   0);
        add(0, 1, 4'h1, 1, S2, F2,   0);
        add(0, 1, 4'h1, 1, S3, F3,   0);
        add(0, 1, 4'h1, 1, S4, E4M,  0);
        add(0, 0, 4'h1, 1, S5, IDLE, 0);
        for (int i = 0; i < 10; i++) begin
            add(0, 0, 4'h1, 1, S1, IDLE, 0);
        end
        add(0, 1, 4'h7, 1, S1, F1,   0);
        // Unknown opcode behaves as NOP.
        add(0, 1, 4'h7, 1, S2, F2,   0);
        add(0, 1, 4'h7, 1, S3, F3,   0);
        add(0, 1, 4'h7, 1, S4, IDLE, 0);
        add(0, 1, 4'h7, 1, S5, IDLE, 0);
        add(0, 1, 4'h7, 1, S6, IDLE, 0);
        // ADD aborted by clr in T5.
        add(0, 1, 4'h1, 1, S1, F1,   0);
        add(0, 1, 4'h1, 1, S2, F2,   0);
        add(0, 1, 4'h1, 1, S3, F3,   0);
        add(0, 1, 4'h1, 1, S4, E4M,  0);
        add(1, 1, 4'h1, 1, S5, IDLE, 0);
        add(0, 1, 4'h1, 1, S1, F1,   0);
        add(0, 1, 4'h1, 1, S2, F2,   0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            clr = vecs[i].clr;
            bus.run_not_prog = vecs[i].run;
            bus.opcode = vecs[i].op;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check_vec(i, e);
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
